hex_display_scanner: RTL and testbench

Parametrised successor to the 4-digit selector. Time-multiplexes NUM_DIGITS hexadecimal digits onto one shared 7-segment bus plus a one-hot digit-select bus. Adds a programmable refresh prescaler, per-frame value snapshot (no tearing), an anti-ghosting guard interval, optional leading-zero blanking and per-digit decimal points. Sits between the datapath value register and the board display pins.

---
 rtl/hex_display_scanner.sv | 115 +++++++++++
 tb/tb_hex_display_scanner.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex 7-segment scanner: prescaled digit slots, per-frame
// value snapshot, guard interval, leading-zero blanking and decimal points.
module hex_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_WIDTH    = 16,
  parameter int DIV_MAX      = 49999,
  parameter int GUARD_CYCLES = 2,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    Enable,
  input  logic                    BlankLeading,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   DpMask,
  output logic [NUM_DIGITS-1:0]   Sw,
  output logic [6:0]              Seg,
  output logic                    Dp,
  output logic                    Frame
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_WIDTH-1:0] PRESC_MAX   = DIV_WIDTH'(DIV_MAX);
  localparam logic [DIV_WIDTH-1:0] PRESC_GUARD = DIV_WIDTH'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0]     IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
  localparam bit                   INVERT      = (ACTIVE_LOW != 0);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [DIV_WIDTH-1:0]    presc_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic [4*NUM_DIGITS-1:0] snap_val_p0;
  logic [NUM_DIGITS-1:0]   snap_dp_p0;
  logic                    tick, last_digit;

  logic [NUM_DIGITS-1:0]   blank_vec;
  logic                    zero_above;
  logic [3:0]              nibble;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   sw_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;

  logic [NUM_DIGITS-1:0]   sw_p1;
  logic [6:0]              seg_p1;
  logic                    dp_p1;
  logic                    frame_p1;

  assign tick       = Enable && (presc_p0 == PRESC_MAX);
  assign last_digit = (idx_p0 == IDX_LAST);

  // Stage 0: prescaler, digit index and frame snapshot
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      presc_p0    <= '0;
      idx_p0      <= '0;
      snap_val_p0 <= '0;
      snap_dp_p0  <= '0;
    end else if (Enable) begin
      presc_p0 <= tick ? '0 : presc_p0 + DIV_WIDTH'(1);
      if (tick) begin
        idx_p0 <= last_digit ? '0 : idx_p0 + IDX_W'(1);
        if (last_digit) begin
          snap_val_p0 <= Value;
          snap_dp_p0  <= DpMask;
        end
      end
    end
  end

  // Blanking walks down from the MSD; digit 0 always stays lit
  always_comb begin
    zero_above = 1'b1;
    blank_vec  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (snap_val_p0[4*i +: 4] == 4'h0);
      if (i > 0) blank_vec[i] = BlankLeading && zero_above;
    end
    nibble  = snap_val_p0[{idx_p0, 2'b00} +: 4];
    lit     = Enable && (presc_p0 >= PRESC_GUARD) && !blank_vec[idx_p0];
    sw_nxt  = lit ? (NUM_DIGITS'(1) << idx_p0) : '0;
    seg_nxt = lit ? hex_to_seg(nibble) : 7'h00;
    dp_nxt  = lit && snap_dp_p0[idx_p0];
  end

  // Stage 1: registered pin drivers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_p1    <= '0;
      seg_p1   <= '0;
      dp_p1    <= 1'b0;
      frame_p1 <= 1'b0;
    end else begin
      sw_p1    <= sw_nxt;
      seg_p1   <= seg_nxt;
      dp_p1    <= dp_nxt;
      frame_p1 <= tick && last_digit;
    end
  end

  assign Sw    = INVERT ? ~sw_p1  : sw_p1;
  assign Seg   = INVERT ? ~seg_p1 : seg_p1;
  assign Dp    = INVERT ? ~dp_p1  : dp_p1;
  assign Frame = frame_p1;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner: 4 digits, 4-clock slots, 1 guard
// clock, active-low pins; expected pin values are hand-derived per sample.
module tb_hex_display_scanner;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Enable = 1'b1;
  logic        BlankLeading = 1'b0;
  logic [15:0] Value = 16'h0000;
  logic [3:0]  DpMask = 4'h0;
  logic [3:0]  Sw;
  logic [6:0]  Seg;
  logic        Dp;
  logic        Frame;

  int total = 0;
  int bad   = 0;

  hex_display_scanner #(
    .NUM_DIGITS(4), .DIV_WIDTH(16), .DIV_MAX(3), .GUARD_CYCLES(1), .ACTIVE_LOW(1)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .BlankLeading(BlankLeading),
    .Value(Value), .DpMask(DpMask), .Sw(Sw), .Seg(Seg), .Dp(Dp), .Frame(Frame)
  );

  always #5 Clock = ~Clock;

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_now(input string tag, input logic [3:0] exp_sw,
                           input logic [6:0] exp_seg, input logic exp_dp,
                           input logic exp_frame);
    total++;
    assert (Sw === exp_sw) else begin
      bad++; $error("FAIL %s sw: observed=%h expected=%h", tag, Sw, exp_sw);
    end
    total++;
    assert (Seg === exp_seg) else begin
      bad++; $error("FAIL %s seg: observed=%h expected=%h", tag, Seg, exp_seg);
    end
    total++;
    assert (Dp === exp_dp) else begin
      bad++; $error("FAIL %s dp: observed=%b expected=%b", tag, Dp, exp_dp);
    end
    total++;
    assert (Frame === exp_frame) else begin
      bad++; $error("FAIL %s frame: observed=%b expected=%b", tag, Frame, exp_frame);
    end
  endtask

  task automatic dark(input string tag, input logic exp_frame);
    @(negedge Clock);
    check_now(tag, 4'hF, 7'h7F, 1'b1, exp_frame);
  endtask

  // code/dp are active-high here; pins are active-low
  task automatic lit(input string tag, input int d, input logic [6:0] code,
                     input logic dp, input logic exp_frame);
    logic [3:0] onehot;
    onehot = 4'b0001 << d;
    @(negedge Clock);
    check_now(tag, ~onehot, ~code, ~dp, exp_frame);
  endtask

  // One slot: guard clock then three lit (or blanked) clocks; Frame on the
  // last clock of digit 3
  task automatic slot(input string tag, input int d, input logic [6:0] code,
                      input logic dp, input logic blank);
    dark(tag, 1'b0);
    for (int p = 1; p < 4; p++) begin
      if (blank) dark(tag, (p == 3) && (d == 3));
      else       lit(tag, d, code, dp, (p == 3) && (d == 3));
    end
  endtask

  initial begin
    // reset state
    #1 Reset_n = 1'b0;
    #1 check_now("rst_async", 4'hF, 7'h7F, 1'b1, 1'b0);
    @(negedge Clock);
    check_now("rst_held", 4'hF, 7'h7F, 1'b1, 1'b0);
    Reset_n = 1'b1;

    // zero frame; new value loaded mid-frame lands in the next snapshot
    slot("t1_d0", 0, 7'h3F, 1'b0, 1'b0);
    slot("t1_d1", 1, 7'h3F, 1'b0, 1'b0);
    slot("t1_d2", 2, 7'h3F, 1'b0, 1'b0);
    Value = 16'h1A2F; DpMask = 4'b0100;
    slot("t1_d3", 3, 7'h3F, 1'b0, 1'b0);

    slot("t2_d0", 0, 7'h71, 1'b0, 1'b0);
    slot("t2_d1", 1, 7'h5B, 1'b0, 1'b0);
    slot("t2_d2", 2, 7'h77, 1'b1, 1'b0);
    Value = 16'h1234; DpMask = 4'b0000;
    slot("t2_d3", 3, 7'h06, 1'b0, 1'b0);

    // snapshot holds 1234 while Value changes to ABCD mid-frame
    slot("t3_d0", 0, 7'h66, 1'b0, 1'b0);
    slot("t3_d1", 1, 7'h4F, 1'b0, 1'b0);
    Value = 16'hABCD;
    slot("t3_d2", 2, 7'h5B, 1'b0, 1'b0);
    slot("t3_d3", 3, 7'h06, 1'b0, 1'b0);

    slot("t3b_d0", 0, 7'h5E, 1'b0, 1'b0);
    slot("t3b_d1", 1, 7'h39, 1'b0, 1'b0);
    slot("t3b_d2", 2, 7'h7C, 1'b0, 1'b0);
    Value = 16'h0050; BlankLeading = 1'b1;
    slot("t3b_d3", 3, 7'h77, 1'b0, 1'b0);

    // leading-zero blanking
    slot("t4_d0", 0, 7'h3F, 1'b0, 1'b0);
    slot("t4_d1", 1, 7'h6D, 1'b0, 1'b0);
    Value = 16'h0000;
    slot("t4_d2", 2, 7'h00, 1'b0, 1'b1);
    slot("t4_d3", 3, 7'h00, 1'b0, 1'b1);

    slot("t4b_d0", 0, 7'h3F, 1'b0, 1'b0);
    slot("t4b_d1", 1, 7'h00, 1'b0, 1'b1);
    slot("t4b_d2", 2, 7'h00, 1'b0, 1'b1);
    slot("t4b_d3", 3, 7'h00, 1'b0, 1'b1);
    BlankLeading = 1'b0;

    // Enable pause mid-slot of digit 1, then resume with 2 lit clocks left
    slot("t5_d0", 0, 7'h3F, 1'b0, 1'b0);
    dark("t5_d1_guard", 1'b0);
    lit("t5_d1_pre", 1, 7'h3F, 1'b0, 1'b0);
    Enable = 1'b0;
    for (int k = 0; k < 10; k++) dark("t5_paused", 1'b0);
    Enable = 1'b1;
    lit("t5_d1_resume", 1, 7'h3F, 1'b0, 1'b0);
    lit("t5_d1_resume", 1, 7'h3F, 1'b0, 1'b0);
    slot("t5_d2", 2, 7'h3F, 1'b0, 1'b0);
    slot("t5_d3", 3, 7'h3F, 1'b0, 1'b0);

    // asynchronous reset mid-slot, then restart from the zero snapshot
    Value = 16'h1A2F; DpMask = 4'hF;
    dark("t6_d0_guard", 1'b0);
    lit("t6_d0_pre", 0, 7'h3F, 1'b0, 1'b0);
    #2 Reset_n = 1'b0;
    #1 check_now("t6_async", 4'hF, 7'h7F, 1'b1, 1'b0);
    @(negedge Clock);
    check_now("t6_held", 4'hF, 7'h7F, 1'b1, 1'b0);
    Reset_n = 1'b1;
    slot("t6_d0", 0, 7'h3F, 1'b0, 1'b0);
    slot("t6_d1", 1, 7'h3F, 1'b0, 1'b0);
    slot("t6_d2", 2, 7'h3F, 1'b0, 1'b0);
    slot("t6_d3", 3, 7'h3F, 1'b0, 1'b0);
    slot("t6b_d0", 0, 7'h71, 1'b1, 1'b0);
    slot("t6b_d1", 1, 7'h5B, 1'b1, 1'b0);
    slot("t6b_d2", 2, 7'h77, 1'b1, 1'b0);
    slot("t6b_d3", 3, 7'h06, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
